// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and default widths.
// Imported by the arbiter and any future bus masters.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam int AHB_AW = 32;
  localparam int AHB_DW = 32;

endpackage

// File: rtl/ahb_rr_pick.sv
// Rotating-priority picker: searches upward from ptr+1.
// Returns a one-hot grant, its index and an any-hit flag.
module ahb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // first requester after the last winner, wrapping modulo N
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    gnt[idx] = any;
  end

endmodule

// File: rtl/ahb_lite_arbiter.sv
// Round-robin share of one AHB-Lite master port.
// Two-deep pipeline: address phase then data phase.
module ahb_lite_arbiter
  import ahb_lite_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = AHB_AW,
  parameter int DW      = AHB_DW
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic [AW-1:0]         HADDR,
  output logic                  HWRITE,
  output logic [1:0]            HTRANS,
  output logic [2:0]            HSIZE,
  output logic [DW-1:0]         HWDATA,
  input  logic [DW-1:0]         HRDATA,
  input  logic                  HREADY
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      win_idx;
  logic               win_any;
  logic [AW-1:0]      win_addr;
  logic [DW-1:0]      win_wdata;

  logic [IW-1:0]      ptr_q, ptr_d;
  logic               a_valid_q, a_valid_d;
  logic               a_write_q, a_write_d;
  logic [IW-1:0]      a_owner_q, a_owner_d;
  logic [DW-1:0]      a_wdata_q, a_wdata_d;
  logic [AW-1:0]      haddr_q, haddr_d;
  logic               d_valid_q, d_valid_d;
  logic               d_write_q, d_write_d;
  logic [IW-1:0]      d_owner_q, d_owner_d;
  logic [DW-1:0]      hwdata_q, hwdata_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;

  ahb_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (win_idx),
    .any (win_any)
  );

  assign win_addr  = req_addr[int'(win_idx)*AW +: AW];
  assign win_wdata = req_wdata[int'(win_idx)*DW +: DW];

  // a grant only counts when the address phase can advance
  assign req_ack = HREADY ? gnt : '0;

  assign HADDR     = haddr_q;
  assign HWRITE    = a_write_q;
  assign HTRANS    = a_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HSIZE     = HSIZE_WORD;
  assign HWDATA    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  // advance both phases together on every ready edge
  always_comb begin
    ptr_d       = ptr_q;
    a_valid_d   = a_valid_q;
    a_write_d   = a_write_q;
    a_owner_d   = a_owner_q;
    a_wdata_d   = a_wdata_q;
    haddr_d     = haddr_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    d_owner_d   = d_owner_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    if (HREADY) begin
      d_valid_d = a_valid_q;
      d_write_d = a_write_q;
      d_owner_d = a_owner_q;
      if (a_valid_q && a_write_q) begin
        hwdata_d = a_wdata_q;
      end
      a_valid_d = win_any;
      if (win_any) begin
        haddr_d   = win_addr;
        a_write_d = req_write[win_idx];
        a_wdata_d = win_wdata;
        a_owner_d = win_idx;
        ptr_d     = win_idx;
      end
      if (d_valid_q) begin
        rsp_valid_d[d_owner_q] = 1'b1;
        rsp_rdata_d = d_write_q ? '0 : HRDATA;
      end
    end
  end

  // pipeline state; reset drops anything in flight
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ptr_q       <= IW'(NUM_REQ - 1);
      a_valid_q   <= 1'b0;
      a_write_q   <= 1'b0;
      a_owner_q   <= '0;
      a_wdata_q   <= '0;
      haddr_q     <= '0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      d_owner_q   <= '0;
      hwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      a_valid_q   <= a_valid_d;
      a_write_q   <= a_write_d;
      a_owner_q   <= a_owner_d;
      a_wdata_q   <= a_wdata_d;
      haddr_q     <= haddr_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      d_owner_q   <= d_owner_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: doc/ahb_lite_arbiter.md
Name: ahb_lite_arbiter

Overview:
- Shares one AHB-Lite master port between NUM_REQ simple requesters (CPU fetch, CPU data, DMA) using round-robin arbitration.
- Each requester presents a write flag, address and write data, the same style of request the CPU stub master takes.
- The block turns requests into pipelined AHB-Lite address and data phases, honours HREADY wait states, and returns a per-requester completion pulse with read data.
- Sits between the CPU/DMA request logic and the AHB-Lite interconnect.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- AW, 32: address width.
- DW, 32: data width.

Ports:
- HCLK, input, 1: bus clock; all state updates on the rising edge.
- HRESET, input, 1: asynchronous, active-high reset.
- req, input, NUM_REQ: request valid, one bit per requester.
- req_write, input, NUM_REQ: 1 = write, 0 = read.
- req_addr, input, NUM_REQ*AW: packed addresses; requester i uses slice i.
- req_wdata, input, NUM_REQ*DW: packed write data; requester i uses slice i.
- req_ack, output, NUM_REQ: combinational; request accepted at the coming edge.
- rsp_valid, output, NUM_REQ: registered one-cycle pulse when the transfer completes.
- rsp_rdata, output, DW: read data, qualified by rsp_valid.
- HADDR, output, AW: AHB address.
- HWRITE, output, 1: AHB write.
- HTRANS, output, 2: IDLE = 2'b00 or NONSEQ = 2'b10 only.
- HSIZE, output, 3: tied to 3'b010 (word).
- HWDATA, output, DW: AHB write data.
- HRDATA, input, DW: AHB read data.
- HREADY, input, 1: AHB ready.

Behaviour:
- Reset (async, while HRESET=1):
  - HTRANS = IDLE; HADDR = 0; HWRITE = 0; HWDATA = 0.
  - rsp_valid = 0; rsp_rdata = 0.
  - Data-phase valid flag cleared.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has highest priority first.
- Arbitration (combinational):
  - The winner is the first requester i with req[i]=1, searching from pointer+1 upward modulo NUM_REQ.
  - req_ack[winner] = HREADY. All other req_ack bits are 0.
  - With HREADY=0 every req_ack bit is 0.
- Edge with HREADY=1, performed together:
  - The current address phase moves to the data phase. Its owner, write flag and valid bit are registered. If it is a valid write, HWDATA <= its stored wdata; otherwise HWDATA holds.
  - If a winner exists: HADDR/HWRITE <= winner's request, HTRANS <= NONSEQ, wdata and owner captured, pointer <= winner.
  - If no winner: HTRANS <= IDLE, and HADDR/HWRITE hold.
  - If the previous data phase was valid, it completes:
    - rsp_valid[owner] = 1 for exactly one cycle.
    - rsp_rdata <= HRDATA for reads and 0 for writes.
- Edge with HREADY=0:
  - All address, data, pointer and HWDATA registers hold.
  - rsp_valid goes to 0.
- Requester rule: after a cycle with req_ack[i]=1, that request is consumed. A requester keeping req[i] high is issuing a new request.
- Latency with zero wait states:
  - Ack in cycle C0.
  - NONSEQ on the bus in C1.
  - Data phase in C2.
  - rsp_valid in C3.
  - Each HREADY=0 cycle in the address or data phase adds one cycle.
- Throughput: back-to-back transfers fully pipelined, one per cycle, with no IDLE inserted.
- Fairness: a continuously requesting requester is acked within NUM_REQ-1 grants to others.
- Reset mid-transfer: in-flight transfers are dropped and no rsp_valid is issued for them. After release the block starts from the reset state.
- Simultaneous events: a completing data phase and a new grant in the same cycle are legal. rsp_valid and req_ack may be high together, for the same or different requesters.

Decomposition:
- Package ahb_lite_pkg holds:
  - HTRANS_IDLE = 2'b00, HTRANS_NONSEQ = 2'b10.
  - HSIZE_WORD = 3'b010.
  - Default AW and DW.
- Sub-module ahb_rr_pick:
  - Combinational rotating-priority picker.
  - Inputs: req and pointer. Outputs: one-hot grant and encoded index.
  - Reused by future arbiters.

Test Plan:
- Reset: assert HRESET mid-simulation → HTRANS=00, HADDR=0, HWDATA=0, rsp_valid=0 immediately, without waiting for HCLK.
- Single write: req0 writes 32'h11111111 to address 32'h11111111 with HREADY=1 → req_ack[0] in C0; HADDR=32'h11111111, HWRITE=1, NONSEQ in C1; HWDATA=32'h11111111 in C2; rsp_valid[0] in C3.
- Pipelined mix: req0 issues write 32'h22222222, then read 32'h33333333 with HRDATA=32'h33333333 → two consecutive NONSEQ cycles; the read's rsp_valid carries rsp_rdata=32'h33333333.
- Contention: req0 and req1 both held high for 4 grants → ack order 0,1,0,1; HADDR alternates between the two request addresses.
- Wait states: HREADY=0 for 2 cycles during the data phase of a read of 32'h77777777 → HADDR, HTRANS and HWDATA stable; no ack during stall; rsp_valid delayed by exactly 2 cycles with rsp_rdata=32'h77777777.
- Reset mid-transfer: HRESET pulse while a read to 32'h88888888 is in its data phase → no rsp_valid for it; after release the next grant goes to req0.
